// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/jump/halt control FSM for the PC + ROM + fetch-register datapath
module fetch_sequencer #(
    parameter int ADDR_W = 12,
    parameter logic [3:0] JMP_OP = 4'hC,
    parameter logic [3:0] JC_OP = 4'hD,
    parameter logic [3:0] JZ_OP = 4'hE,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input logic clck,
    input logic rst,
    input logic run,
    input logic resume,
    input logic halt_req,
    input logic [7:0] pb,
    input logic [3:0] instr,
    input logic [3:0] oprnd,
    input logic flag_c,
    input logic flag_z,
    output logic en_pc,
    output logic en_fetch,
    output logic ld_pc,
    output logic [ADDR_W-1:0] load_addr,
    output logic exec_stb,
    output logic halted,
    output logic [2:0] state
);
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, JADDR = 3'd3, JLOAD = 3'd4, HALT = 3'd5;
    logic [2:0] next;
    logic [ADDR_W-9:0] addr_hi;
    logic [7:0] addr_lo;
    logic taken;
    logic is_hlt, is_jmp, cond;
    assign is_hlt = instr == HLT_OP;
    assign is_jmp = instr == JMP_OP || instr == JC_OP || instr == JZ_OP;
    assign cond = instr == JMP_OP || (instr == JC_OP && flag_c) || (instr == JZ_OP && flag_z);
    always_ff @(posedge clck) begin
        if (rst) begin
            state <= IDLE;
            addr_hi <= '0;
            addr_lo <= '0;
            taken <= 1'b0;
        end else begin
            state <= next;
            if (state == DECODE && is_jmp) begin
                addr_hi <= oprnd[ADDR_W-9:0];
                taken <= cond;
            end
            if (state == JADDR) addr_lo <= pb;
        end
    end
    always_comb begin
        next = IDLE;
        case (state)
            IDLE: next = run ? FETCH : IDLE;
            FETCH: next = DECODE;
            DECODE: next = is_hlt ? HALT : is_jmp ? JADDR : halt_req ? HALT : FETCH;
            JADDR: next = taken ? JLOAD : halt_req ? HALT : FETCH;
            JLOAD: next = halt_req ? HALT : FETCH;
            HALT: next = resume ? FETCH : HALT;
            default: next = IDLE;
        endcase
    end
    always_comb begin
        en_fetch = state == FETCH;
        en_pc = (state == DECODE && !is_hlt) || (state == JADDR && !taken);
        exec_stb = state == DECODE && !is_hlt && !is_jmp;
        ld_pc = state == JLOAD;
        load_addr = ld_pc ? {addr_hi, addr_lo} : '0;
        halted = state == HALT;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer driving a PC/ROM/fetch-register model
module tb_fetch_sequencer;
    logic clck = 1'b0;
    logic rst = 1'b1, run = 1'b0, resume = 1'b0, halt_req = 1'b0, flag_c = 1'b0, flag_z = 1'b0;
    logic [7:0] pb, fr;
    logic [11:0] pc, load_addr;
    logic en_pc, en_fetch, ld_pc, exec_stb, halted;
    logic [2:0] state;
    logic [7:0] rom [4096];
    int total = 0, bad = 0, execs;

    always #5 clck = ~clck;

    fetch_sequencer dut (
        .clck(clck), .rst(rst), .run(run), .resume(resume), .halt_req(halt_req),
        .pb(pb), .instr(fr[7:4]), .oprnd(fr[3:0]), .flag_c(flag_c), .flag_z(flag_z),
        .en_pc(en_pc), .en_fetch(en_fetch), .ld_pc(ld_pc), .load_addr(load_addr),
        .exec_stb(exec_stb), .halted(halted), .state(state)
    );

    assign pb = rom[pc];
    always @(posedge clck) begin
        if (rst) begin
            pc <= '0;
            fr <= '0;
        end else begin
            pc <= ld_pc ? load_addr : en_pc ? pc + 12'd1 : pc;
            if (en_fetch) fr <= pb;
        end
    end

    task automatic tick();
        @(negedge clck);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobes(input string tag, input logic [4:0] exp);
        chk(tag, {en_fetch, en_pc, ld_pc, exec_stb, halted}, {27'd0, exp});
    endtask

    task automatic restart();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rst = 1'b1;
        run = 1'b0;
        halt_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset mid-JADDR
        restart();
        rom[0] = 8'hC4; rom[1] = 8'h56;
        run = 1'b1;
        tick(); tick(); tick();
        chk("jaddr_reached", state, 3);
        rst = 1'b1;
        tick();
        chk("rst_state1", state, 0);
        strobes("rst_strobes1", 5'b00000);
        chk("rst_load_addr", load_addr, 0);
        tick();
        chk("rst_state2", state, 0);
        rst = 1'b0;
        run = 1'b0;
        tick(); tick(); tick();
        chk("idle_hold", state, 0);
        strobes("idle_strobes", 5'b00000);

        // linear program then HALT at 3
        restart();
        rom[0] = 8'h13; rom[1] = 8'h24; rom[2] = 8'h35; rom[3] = 8'hF0;
        run = 1'b1;
        execs = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lin_fetch_state", state, 1);
            strobes("lin_fetch_strobes", 5'b10000);
            chk("lin_fetch_pc", pc, i);
            tick();
            chk("lin_decode_state", state, 2);
            strobes("lin_decode_strobes", 5'b01010);
            if (exec_stb) execs++;
        end
        tick();
        chk("lin_pc3", pc, 3);
        chk("lin_execs", execs, 3);
        tick();
        chk("hlt_decode", state, 2);
        strobes("hlt_decode_strobes", 5'b00000);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_state", state, 5);
            strobes("halt_strobes", 5'b00001);
            chk("halt_pc", pc, 3);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_fetch", state, 1);
        chk("resume_pc", pc, 3);
        tick(); tick();
        chk("rehalt", halted, 1);
        chk("rehalt_pc", pc, 3);

        // unconditional jump
        restart();
        rom[0] = 8'hC4; rom[1] = 8'h56;
        run = 1'b1;
        tick(); tick();
        strobes("jmp_decode", 5'b01000);
        tick();
        chk("jmp_jaddr", state, 3);
        strobes("jmp_jaddr_strobes", 5'b00000);
        tick();
        strobes("jmp_jload", 5'b00100);
        chk("jmp_addr", load_addr, 12'h456);
        tick();
        strobes("jmp_fetch", 5'b10000);
        chk("jmp_pc", pc, 12'h456);

        // JZ not taken
        restart();
        rom[0] = 8'hE1; rom[1] = 8'h20; rom[2] = 8'hF0;
        flag_z = 1'b0;
        run = 1'b1;
        tick(); tick();
        strobes("jz_nt_decode", 5'b01000);
        tick();
        strobes("jz_nt_jaddr", 5'b01000);
        tick();
        chk("jz_nt_fetch", state, 1);
        chk("jz_nt_pc", pc, 2);

        // JZ taken
        restart();
        rom[0] = 8'hE1; rom[1] = 8'h20;
        flag_z = 1'b1;
        run = 1'b1;
        tick(); tick(); tick(); tick();
        strobes("jz_t_jload", 5'b00100);
        chk("jz_t_addr", load_addr, 12'h120);
        tick();
        chk("jz_t_pc", pc, 12'h120);

        // jump to FFF whose low byte wraps to 000
        restart();
        rom[0] = 8'hCF; rom[1] = 8'hFF; rom[12'hFFF] = 8'hE1;
        flag_z = 1'b1;
        run = 1'b1;
        tick(); tick(); tick(); tick();
        chk("wrap_jload", load_addr, 12'hFFF);
        tick(); tick(); tick();
        chk("wrap_pc0", pc, 0);
        chk("wrap_jaddr", state, 3);
        tick();
        chk("wrap_addr", load_addr, 12'h1CF);
        flag_z = 1'b0;

        // halt_req during DECODE
        restart();
        rom[0] = 8'h13;
        run = 1'b1;
        tick(); tick();
        halt_req = 1'b1;
        strobes("hreq_decode", 5'b01010);
        tick();
        halt_req = 1'b0;
        chk("hreq_halted", halted, 1);
        chk("hreq_pc", pc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
